// File: rtl/ram_arbiter_pkg.sv
// Shared widths and ownership-state encoding for the RAM arbiter.
package ram_arbiter_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned AddrWidth = 7;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLock0 = 2'd1,
        StLock1 = 2'd2
    } own_state_e;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-input round-robin picker; ties go to the input not granted most recently.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // 1 = requester 1 won last, so requester 0 wins the next tie.
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter with optional lock in front of a single-port registered-output RAM.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned Data_width = DataWidth,
    parameter int unsigned Addr_width = AddrWidth
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_valid_0,
    output logic                  req_ready_0,
    input  logic                  req_we_0,
    input  logic                  req_lock_0,
    input  logic [Addr_width-1:0] req_addr_0,
    input  logic [Data_width-1:0] req_wdata_0,
    output logic                  rsp_valid_0,
    output logic [Data_width-1:0] rsp_rdata_0,

    input  logic                  req_valid_1,
    output logic                  req_ready_1,
    input  logic                  req_we_1,
    input  logic                  req_lock_1,
    input  logic [Addr_width-1:0] req_addr_1,
    input  logic [Data_width-1:0] req_wdata_1,
    output logic                  rsp_valid_1,
    output logic [Data_width-1:0] rsp_rdata_1,

    output logic                  ram_we,
    output logic [Addr_width-1:0] ram_address,
    output logic [Data_width-1:0] ram_d,
    input  logic [Data_width-1:0] ram_q
);

    own_state_e            state_q, state_d;
    logic [1:0]            req_mask;
    logic [1:0]            req_masked;
    logic [1:0]            gnt;
    logic                  any_gnt;
    logic                  sel_we;
    logic                  sel_lock;
    logic [Addr_width-1:0] sel_addr;
    logic [Data_width-1:0] sel_data;
    logic [Addr_width-1:0] addr_q;
    logic [Data_width-1:0] data_q;
    logic [1:0]            rsp_valid_q;

    always_comb begin
        req_mask = 2'b11;
        unique case (state_q)
            StIdle:  req_mask = 2'b11;
            StLock0: req_mask = 2'b01;
            StLock1: req_mask = 2'b10;
            default: req_mask = 2'b11;
        endcase
    end

    // No grant, hence no transfer or RAM write, while reset is held.
    assign req_masked = {req_valid_1, req_valid_0} & req_mask & {2{~reset}};

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req_masked),
        .update (any_gnt),
        .gnt    (gnt)
    );

    assign any_gnt     = |gnt;
    assign req_ready_0 = gnt[0];
    assign req_ready_1 = gnt[1];

    assign sel_we   = gnt[1] ? req_we_1    : req_we_0;
    assign sel_lock = gnt[1] ? req_lock_1  : req_lock_0;
    assign sel_addr = gnt[1] ? req_addr_1  : req_addr_0;
    assign sel_data = gnt[1] ? req_wdata_1 : req_wdata_0;

    assign ram_we      = any_gnt & sel_we;
    assign ram_address = any_gnt ? sel_addr : addr_q;
    assign ram_d       = any_gnt ? sel_data : data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (any_gnt) begin
            addr_q <= sel_addr;
            data_q <= sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 2'b00;
        end else begin
            rsp_valid_q <= gnt & {2{~sel_we}};
        end
    end

    // Gated so a read granted just before reset never reports a response.
    assign rsp_valid_0 = rsp_valid_q[0] & ~reset;
    assign rsp_valid_1 = rsp_valid_q[1] & ~reset;
    assign rsp_rdata_0 = ram_q;
    assign rsp_rdata_1 = ram_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (gnt[0] && req_lock_0) begin
                    state_d = StLock0;
                end else if (gnt[1] && req_lock_1) begin
                    state_d = StLock1;
                end
            end
            StLock0: if (gnt[0] && !sel_lock) state_d = StIdle;
            StLock1: if (gnt[1] && !sel_lock) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
